ram_burst_ctrl: RTL

- Burst sequencer directly upstream of the single-port 8-bit RAM. It is the only block that drives the RAM's write-enable, address and data-in ports, and it consumes the RAM's data-out.
- Accepts one burst command at a time, then either streams write data into consecutive RAM addresses or streams read data out of them.
- All streams use valid/ready handshakes, so producers and consumers never see the RAM's read latency or its write-versus-read port sharing.

---
 rtl/ram_burst_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port synchronous RAM. It takes one command at a time and
// streams write beats into, or read beats out of, consecutive addresses using valid/ready handshakes.
module ram_burst_ctrl #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRdIssue,
      StRdWait,
      StRdOut
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      cmd_ready  = 1'b0;
      wr_ready   = 1'b0;
      ram_we     = 1'b0;
      ram_din    = '0;

      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               cnt_d   = cmd_len;
               state_d = cmd_write ? StWrite : StRdIssue;
            end
         end

         // Write data passes straight through to the RAM in the handshake cycle.
         StWrite: begin
            wr_ready = 1'b1;
            ram_we   = wr_valid;
            ram_din  = wr_data;
            if (wr_valid) begin
               addr_d = addr_q + ADDR_W'(1);
               cnt_d  = cnt_q - ADDR_W'(1);
               if (cnt_q == '0) begin
                  state_d = StIdle;
               end
            end
         end

         StRdIssue: begin
            state_d = StRdWait;
         end

         // ram_dout now reflects the address presented during the issue cycle.
         StRdWait: begin
            rd_data_d  = ram_dout;
            rd_valid_d = 1'b1;
            state_d    = StRdOut;
         end

         StRdOut: begin
            if (rd_ready) begin
               rd_valid_d = 1'b0;
               if (cnt_q == '0) begin
                  state_d = StIdle;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  cnt_d   = cnt_q - ADDR_W'(1);
                  state_d = StRdIssue;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign ram_addr = addr_q;
   assign busy     = (state_q != StIdle);
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule
